// File: rtl/maxpool_layer_1.sv
// maxpool_layer_1: 2x2/stride-2 max pooling with ReLU over two 28x28 channels.
// The block walks the 392 output positions one per cycle, so only one
// four-input compare is built. It selects that position's window straight from
// the feature map, which must therefore stay stable while busy is high.

// Signed maximum of four values, clamped at zero (ReLU).
module maxpool_relu4 #(
  parameter int bitwidth = 32
) (
  input  logic signed [bitwidth-1:0] i_a,
  input  logic signed [bitwidth-1:0] i_b,
  input  logic signed [bitwidth-1:0] i_c,
  input  logic signed [bitwidth-1:0] i_d,
  output logic signed [bitwidth-1:0] o_y
);

  logic signed [bitwidth-1:0] w_m_ab;
  logic signed [bitwidth-1:0] w_m_cd;
  logic signed [bitwidth-1:0] w_m_all;

  // Balanced compare tree. Ties pick either operand, and both give the same value.
  // The zero floor also covers the most-negative input.
  always_comb begin
    w_m_ab  = (i_a > i_b) ? i_a : i_b;
    w_m_cd  = (i_c > i_d) ? i_c : i_d;
    w_m_all = (w_m_ab > w_m_cd) ? w_m_ab : w_m_cd;
    o_y     = (w_m_all > 0) ? w_m_all : '0;
  end

endmodule

module maxpool_layer_1 #(
  parameter int bitwidth = 32
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    start,
  input  logic [1:0][27:0][27:0][bitwidth-1:0]    featuremap,
  output logic [1:0][13:0][13:0][bitwidth-1:0]    pooled,
  output logic                                    busy,
  output logic                                    done,
  output logic                                    out_valid,
  output logic [bitwidth-1:0]                     out_data,
  output logic                                    out_ch,
  output logic [3:0]                              out_row,
  output logic [3:0]                              out_col
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] LAST_IDX = 4'd13;

  logic [1:0]                                 r_state;
  logic                                       r_ch;
  logic [3:0]                                 r_row;
  logic [3:0]                                 r_col;
  logic [1:0][13:0][13:0][bitwidth-1:0]       r_pooled;
  logic                                       r_done;
  logic                                       r_out_valid;
  logic [bitwidth-1:0]                        r_out_data;
  logic                                       r_out_ch;
  logic [3:0]                                 r_out_row;
  logic [3:0]                                 r_out_col;

  logic [4:0]                                 w_y0;
  logic [4:0]                                 w_y1;
  logic [4:0]                                 w_x0;
  logic [4:0]                                 w_x1;
  logic signed [bitwidth-1:0]                 w_p00;
  logic signed [bitwidth-1:0]                 w_p01;
  logic signed [bitwidth-1:0]                 w_p10;
  logic signed [bitwidth-1:0]                 w_p11;
  logic signed [bitwidth-1:0]                 w_max;
  logic                                       w_run;
  logic                                       w_col_wrap;
  logic                                       w_row_wrap;
  logic                                       w_last;

  // Window origin is (2*row, 2*col); the odd row/column is just the low bit set.
  always_comb begin
    w_y0  = {r_row, 1'b0};
    w_y1  = {r_row, 1'b1};
    w_x0  = {r_col, 1'b0};
    w_x1  = {r_col, 1'b1};
    w_p00 = featuremap[r_ch][w_y0][w_x0];
    w_p01 = featuremap[r_ch][w_y0][w_x1];
    w_p10 = featuremap[r_ch][w_y1][w_x0];
    w_p11 = featuremap[r_ch][w_y1][w_x1];
  end

  maxpool_relu4 #(.bitwidth(bitwidth)) u_relu4 (
    .i_a (w_p00),
    .i_b (w_p01),
    .i_c (w_p10),
    .i_d (w_p11),
    .o_y (w_max)
  );

  // Scan position decode: column fastest, then row, then channel.
  always_comb begin
    w_run      = (r_state == S_RUN);
    w_col_wrap = (r_col == LAST_IDX);
    w_row_wrap = (r_row == LAST_IDX);
    w_last     = r_ch && w_row_wrap && w_col_wrap;
  end

  // Control FSM and scan counters. Start is only honoured from IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ch    <= 1'b0;
      r_row   <= '0;
      r_col   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_RUN;
            r_ch    <= 1'b0;
            r_row   <= '0;
            r_col   <= '0;
          end
        end
        S_RUN: begin
          if (w_last) begin
            r_state <= S_DONE;
            r_ch    <= 1'b0;
            r_row   <= '0;
            r_col   <= '0;
          end else if (w_col_wrap) begin
            r_col <= '0;
            if (w_row_wrap) begin
              r_row <= '0;
              r_ch  <= 1'b1;
            end else begin
              r_row <= r_row + 4'd1;
            end
          end else begin
            r_col <= r_col + 4'd1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Result storage: one entry written per RUN cycle; the rest hold between runs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pooled <= '0;
    end else if (w_run) begin
      r_pooled[r_ch][r_row][r_col] <= w_max;
    end
  end

  // Write-report stream, one cycle behind the write it describes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= 1'b0;
      r_out_row   <= '0;
      r_out_col   <= '0;
    end else begin
      r_out_valid <= w_run;
      if (w_run) begin
        r_out_data <= w_max;
        r_out_ch   <= r_ch;
        r_out_row  <= r_row;
        r_out_col  <= r_col;
      end
    end
  end

  // Completion pulse lands in the cycle after the DONE state,
  // which is also the cycle after the last out_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_done <= 1'b0;
    end else begin
      r_done <= (r_state == S_DONE);
    end
  end

  // Busy covers the RUN cycles plus DONE, where the final write is still being reported.
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign pooled    = r_pooled;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;
  assign out_row   = r_out_row;
  assign out_col   = r_out_col;

endmodule

// File: tb/tb_maxpool_layer_1.sv
// Bench for maxpool_layer_1: directed runs over formula, constant and random
// feature maps. Each run is checked cycle by cycle against a max/ReLU model.
module tb_maxpool_layer_1;

  localparam int BW = 32;

  logic                              clk = 1'b0;
  logic                              rst;
  logic                              start;
  logic [1:0][27:0][27:0][BW-1:0]    fm;
  logic [1:0][13:0][13:0][BW-1:0]    pooled;
  logic                              busy;
  logic                              done;
  logic                              out_valid;
  logic [BW-1:0]                     out_data;
  logic                              out_ch;
  logic [3:0]                        out_row;
  logic [3:0]                        out_col;

  int checks = 0;
  int errors = 0;
  int nvalid;
  logic [BW-1:0] exp_pool [2][14][14];

  always #5 clk = ~clk;

  maxpool_layer_1 #(.bitwidth(BW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .featuremap (fm),
    .pooled     (pooled),
    .busy       (busy),
    .done       (done),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ch     (out_ch),
    .out_row    (out_row),
    .out_col    (out_col)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: the largest of the four window values and zero, compared as signed integers.
  function automatic void build_model();
    for (int c = 0; c < 2; c++)
      for (int r = 0; r < 14; r++)
        for (int q = 0; q < 14; q++) begin
          int m;
          m = 0;
          for (int dy = 0; dy < 2; dy++)
            for (int dx = 0; dx < 2; dx++) begin
              int v;
              v = $signed(fm[c][2*r+dy][2*q+dx]);
              if (v > m) m = v;
            end
          exp_pool[c][r][q] = m;
        end
  endfunction

  function automatic logic [BW-1:0] rand_elem();
    logic [BW-1:0] v;
    case ($urandom_range(0, 5))
      0:       v = 32'h8000_0000;
      1:       v = 32'h7fff_ffff;
      2:       v = int'($urandom_range(0, 6)) - 3;
      3:       v = -int'($urandom_range(1, 1000));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  task automatic fill_random();
    for (int c = 0; c < 2; c++)
      for (int y = 0; y < 28; y++)
        for (int x = 0; x < 28; x++)
          fm[c][y][x] = rand_elem();
  endtask

  task automatic check_pooled(input string tag, input bit zero);
    for (int c = 0; c < 2; c++)
      for (int r = 0; r < 14; r++)
        for (int q = 0; q < 14; q++)
          chk($sformatf("%s[%0d][%0d][%0d]", tag, c, r, q), pooled[c][r][q],
              zero ? '0 : exp_pool[c][r][q]);
  endtask

  // Pulse start, then sample each following cycle at the falling edge (k = cycles since start was sampled).
  // restart_at: re-pulse start in RUN cycle k; rst_at: assert reset in RUN cycle k.
  task automatic run(input string tag, input int restart_at, input int rst_at, output int nv);
    nv = 0;
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= 396; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (rst_at != 0 && k == rst_at + 1) begin
        chk({tag, " abort busy"}, busy, 1'b0);
        chk({tag, " abort done"}, done, 1'b0);
        chk({tag, " abort valid"}, out_valid, 1'b0);
        chk({tag, " abort data"}, out_data, '0);
        check_pooled({tag, " abort pooled"}, 1'b1);
        rst = 1'b0;
        for (int j = 0; j < 5; j++) begin
          @(negedge clk);
          chk({tag, " idle busy"}, busy, 1'b0);
          chk({tag, " idle done"}, done, 1'b0);
          chk({tag, " idle valid"}, out_valid, 1'b0);
        end
        break;
      end
      chk($sformatf("%s busy k=%0d", tag, k), busy, (k <= 393));
      chk($sformatf("%s valid k=%0d", tag, k), out_valid, (k >= 2 && k <= 393));
      chk($sformatf("%s done k=%0d", tag, k), done, (k == 394));
      if (k >= 2 && k <= 393) begin
        int idx, c, r, q;
        idx = k - 2;
        c = idx / 196;
        r = (idx % 196) / 14;
        q = idx % 14;
        if (out_valid) nv++;
        chk($sformatf("%s ch k=%0d", tag, k), out_ch, c);
        chk($sformatf("%s row k=%0d", tag, k), out_row, r);
        chk($sformatf("%s col k=%0d", tag, k), out_col, q);
        chk($sformatf("%s data k=%0d", tag, k), out_data, exp_pool[c][r][q]);
      end
      if (rst_at != 0 && k == rst_at) rst = 1'b1;
      if (k == restart_at || k == 393) start = 1'b1;
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    fm    = '0;
    repeat (3) @(negedge clk);
    chk("rst busy", busy, 1'b0);
    chk("rst done", done, 1'b0);
    chk("rst valid", out_valid, 1'b0);
    chk("rst data", out_data, '0);
    chk("rst ch", out_ch, 1'b0);
    chk("rst row", out_row, 4'd0);
    chk("rst col", out_col, 4'd0);
    check_pooled("rst pooled", 1'b1);
    rst = 1'b0;
    @(negedge clk);
    chk("post-rst busy", busy, 1'b0);

    // Formula map: max of each window is its bottom-right element.
    for (int c = 0; c < 2; c++)
      for (int y = 0; y < 28; y++)
        for (int x = 0; x < 28; x++)
          fm[c][y][x] = c * 1000 + y * 28 + x;
    build_model();
    run("ramp", 0, 0, nvalid);
    chk("ramp count", nvalid, 392);
    check_pooled("ramp pooled", 1'b0);
    chk("ramp p000", pooled[0][0][0], 29);
    chk("ramp p057", pooled[0][5][7], 11 * 28 + 15);
    chk("ramp p11313", pooled[1][13][13], 1000 + 27 * 28 + 27);
    chk("ramp p1013", pooled[1][0][13], 1000 + 28 + 27);

    // All -5: every entry becomes 0 and overwrites the previous run; start re-pulsed mid-run.
    for (int c = 0; c < 2; c++)
      for (int y = 0; y < 28; y++)
        for (int x = 0; x < 28; x++)
          fm[c][y][x] = -5;
    build_model();
    run("neg", 100, 0, nvalid);
    chk("neg count", nvalid, 392);
    check_pooled("neg pooled", 1'b0);

    // Random map with a directed first window containing ties and the most negative value.
    fill_random();
    fm[0][0][0] = 7;
    fm[0][0][1] = -3;
    fm[0][1][0] = 7;
    fm[0][1][1] = 32'h8000_0000;
    build_model();
    run("win", 0, 0, nvalid);
    chk("win count", nvalid, 392);
    chk("win p000", pooled[0][0][0], 7);
    check_pooled("win pooled", 1'b0);

    // Reset in RUN cycle 200, then a full run on a new random map.
    fill_random();
    build_model();
    run("abort", 0, 200, nvalid);
    run("rerun", 0, 0, nvalid);
    chk("rerun count", nvalid, 392);
    check_pooled("rerun pooled", 1'b0);

    fill_random();
    build_model();
    run("rand", 0, 0, nvalid);
    chk("rand count", nvalid, 392);
    check_pooled("rand pooled", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
